vga_controller: RTL

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_counter.sv | 17 +
 rtl/vga_controller.sv | 62 ++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and shared widths for the VGA controller.
package vga_pkg;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;
  localparam int COLOR_W = 3;
  localparam int CNT_W   = 10;
  localparam int POS_W   = 12;
endpackage

// File: rtl/vga_counter.sv
// vga_counter: modulo-N counter with enable and a wrap pulse on the last count.
module vga_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  assign wrap = en && count == LAST;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (en) count <= wrap ? '0 : count + W'(1);
endmodule

// File: rtl/vga_controller.sv
// vga_controller: VGA timing generator; RGB and syncs share one register stage.
module vga_controller
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic [COLOR_W-1:0] color,
  output logic [POS_W-1:0]   x,
  output logic [POS_W-1:0]   y,
  output logic               video_on,
  output logic               frame_end,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [3:0]         VGA_R,
  output logic [3:0]         VGA_G,
  output logic [3:0]         VGA_B
);
  localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [CNT_W-1:0] HV  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] VV  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HSS = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HSE = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VSS = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VSE = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  vga_counter #(.N(HT), .W(CNT_W)) u_h (
    .clk(CLOCK_25), .rst(reset), .en(1'b1), .count(h_cnt), .wrap(h_wrap)
  );
  vga_counter #(.N(VT), .W(CNT_W)) u_v (
    .clk(CLOCK_25), .rst(reset), .en(h_wrap), .count(v_cnt), .wrap(v_wrap)
  );
  assign video_on  = h_cnt < HV && v_cnt < VV;
  assign x         = video_on ? POS_W'(h_cnt) + POS_W'(1) : '0;
  assign y         = video_on ? POS_W'(v_cnt) + POS_W'(1) : '0;
  assign frame_end = v_wrap;
  // Syncs are registered alongside RGB so all DAC-side signals line up.
  always_ff @(posedge CLOCK_25)
    if (reset) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else begin
      VGA_R  <= video_on ? {4{color[2]}} : '0;
      VGA_G  <= video_on ? {4{color[1]}} : '0;
      VGA_B  <= video_on ? {4{color[0]}} : '0;
      VGA_HS <= !(h_cnt >= HSS && h_cnt <= HSE);
      VGA_VS <= !(v_cnt >= VSS && v_cnt <= VSE);
    end
endmodule
